// File: rtl/stream_rr_arb_flush_ctrl_pkg.sv
// Shared definitions for the flushable round-robin stream arbiter.
// Contents:
//   flush_state_e  - flush sequencer states (2-bit)
//   idx_width()    - width of a source index for a given requester count
//   rr_successor() - next round-robin start position after a grant
package stream_rr_arb_flush_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAIN_IN = 2'd1,
        FLUSH    = 2'd2,
        ACK      = 2'd3
    } flush_state_e;

    // A single requester still needs one index bit to keep the ports legal.
    function automatic int unsigned idx_width(input int unsigned num);
        return (num > 1) ? $clog2(num) : 1;
    endfunction

    // Wrap explicitly so a requester count that is not a power of two works.
    function automatic int unsigned rr_successor(input int unsigned g, input int unsigned num);
        return (g == num - 1) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/spill_register_flushable.sv
// Two-entry registered spill buffer with a synchronous flush.
// Ports:
//   clk_i, rst_ni       - clock, asynchronous active-low reset
//   valid_i/ready_o     - input handshake, ready_o low only when both entries hold data
//   data_i              - input payload
//   valid_o/ready_i     - output handshake, output always presents the oldest entry
//   data_o              - output payload
//   flush_i             - empties both entries at the next edge and blocks new input
module spill_register_flushable #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [Width-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [Width-1:0] data_o,
    input  logic             flush_i
);

    logic             a_full_q, b_full_q;
    logic [Width-1:0] a_data_q, b_data_q;
    logic             a_fill, a_drain, b_fill, b_drain;

    // Entry a takes new beats; b only holds a beat that could not leave
    // while a is being refilled, so b is always the older one when full.
    assign ready_o = !(a_full_q && b_full_q);
    assign a_fill  = valid_i && ready_o && !flush_i;
    assign a_drain = (a_full_q && !b_full_q) || flush_i;
    assign b_fill  = a_drain && !ready_i && !flush_i;
    assign b_drain = (b_full_q && ready_i) || flush_i;
    assign valid_o = a_full_q || b_full_q;
    assign data_o  = b_full_q ? b_data_q : a_data_q;

    // Entry occupancy and payload storage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_full_q <= 1'b0;
            b_full_q <= 1'b0;
            a_data_q <= '0;
            b_data_q <= '0;
        end else begin
            if (a_fill) begin
                a_full_q <= 1'b1;
                a_data_q <= data_i;
            end else if (a_drain) begin
                a_full_q <= 1'b0;
            end
            if (b_fill) begin
                b_full_q <= 1'b1;
                b_data_q <= a_data_q;
            end else if (b_drain) begin
                b_full_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/stream_rr_arb_flush_ctrl.sv
// Round-robin arbiter sharing one flushable two-entry spill buffer between
// NumInp valid/ready requesters, tagging every beat with its source index,
// plus a flush sequencer that discards buffered beats on request.
// Ports:
//   clk_i, rst_ni            - clock, asynchronous active-low reset
//   inp_valid_i/inp_ready_o  - per-requester handshake (ready one-hot or zero)
//   inp_data_i               - packed payloads, requester i at [i*DataWidth +: DataWidth]
//   oup_valid_o/oup_ready_i  - output handshake
//   oup_data_o, oup_idx_o    - output payload and its source index
//   flush_req_i              - flush request, sampled in IDLE only
//   flush_ack_o              - one-cycle pulse when the flush is complete
//   busy_o                   - sequencer active or buffer holding data
module stream_rr_arb_flush_ctrl
    import stream_rr_arb_flush_ctrl_pkg::*;
#(
    parameter int unsigned NumInp    = 4,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned IdxWidth  = idx_width(NumInp)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NumInp-1:0]           inp_valid_i,
    output logic [NumInp-1:0]           inp_ready_o,
    input  logic [NumInp*DataWidth-1:0] inp_data_i,
    output logic                        oup_valid_o,
    input  logic                        oup_ready_i,
    output logic [DataWidth-1:0]        oup_data_o,
    output logic [IdxWidth-1:0]         oup_idx_o,
    input  logic                        flush_req_i,
    output logic                        flush_ack_o,
    output logic                        busy_o
);

    typedef logic [IdxWidth-1:0] idx_t;

    flush_state_e                  state_q;
    idx_t                          rr_q, lock_idx_q, arb_idx, grant_idx;
    logic                          lock_q, arb_found, flush_ack_q;
    logic                          grant_en, buf_in_valid, buf_in_ready, in_hs;
    logic                          buf_flush, buf_out_valid;
    logic [IdxWidth+DataWidth-1:0] buf_in_data, buf_out_data;

    // Search for the first valid requester starting at rr_q and wrapping.
    always_comb begin
        int unsigned cand;
        cand      = 0;
        arb_idx   = rr_q;
        arb_found = 1'b0;
        for (int unsigned k = 0; k < NumInp; k++) begin
            cand = 32'(rr_q) + k;
            if (cand >= NumInp) begin
                cand = cand - NumInp;
            end
            if (!arb_found && inp_valid_i[idx_t'(cand)]) begin
                arb_found = 1'b1;
                arb_idx   = idx_t'(cand);
            end
        end
    end

    // A stalled requester keeps the grant until it completes. Grants are
    // also gated by rst_ni so no ready can leak out while reset is held.
    assign grant_idx    = lock_q ? lock_idx_q : arb_idx;
    assign grant_en     = rst_ni && ((state_q == IDLE) || ((state_q == DRAIN_IN) && lock_q));
    assign buf_in_valid = grant_en && inp_valid_i[grant_idx];
    assign in_hs        = buf_in_valid && buf_in_ready;
    assign buf_in_data  = {grant_idx, inp_data_i[grant_idx*DataWidth +: DataWidth]};

    always_comb begin
        inp_ready_o = '0;
        if (in_hs) begin
            inp_ready_o[grant_idx] = 1'b1;
        end
    end

    assign buf_flush = (state_q == FLUSH);

    spill_register_flushable #(
        .Width (IdxWidth + DataWidth)
    ) i_spill (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (buf_in_valid),
        .ready_o (buf_in_ready),
        .data_i  (buf_in_data),
        .valid_o (buf_out_valid),
        .ready_i (oup_ready_i),
        .data_o  (buf_out_data),
        .flush_i (buf_flush)
    );

    // Beats still sitting in the buffer during FLUSH are being discarded.
    assign oup_valid_o = buf_out_valid && !buf_flush;
    assign oup_idx_o   = buf_out_data[IdxWidth+DataWidth-1 -: IdxWidth];
    assign oup_data_o  = buf_out_data[DataWidth-1:0];
    assign flush_ack_o = flush_ack_q;
    assign busy_o      = (state_q != IDLE) || buf_out_valid;

    // Lock, round-robin pointer and flush sequencer. DRAIN_IN may leave in
    // the same cycle a locked beat hands over, since the lock clears then.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            lock_q      <= 1'b0;
            lock_idx_q  <= '0;
            flush_ack_q <= 1'b0;
        end else begin
            if (in_hs) begin
                lock_q <= 1'b0;
                rr_q   <= idx_t'(rr_successor(32'(grant_idx), NumInp));
            end else if (buf_in_valid) begin
                lock_q     <= 1'b1;
                lock_idx_q <= grant_idx;
            end
            if (state_q == FLUSH) begin
                rr_q <= '0;
            end
            flush_ack_q <= (state_q == FLUSH);
            unique case (state_q)
                IDLE:     if (flush_req_i) state_q <= DRAIN_IN;
                DRAIN_IN: if (!lock_q || in_hs) state_q <= FLUSH;
                FLUSH:    state_q <= ACK;
                ACK:      state_q <= IDLE;
                default:  state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_rr_arb_flush_ctrl.sv
// Self-checking bench for stream_rr_arb_flush_ctrl. A queue-based reference
// model tracks buffered beats, the round-robin start point, the pending
// stalled grant and the flush phase, and predicts every visible output.
module tb_stream_rr_arb_flush_ctrl;

    localparam int NumInp = 4;
    localparam int DW     = 32;

    logic               clk_i = 1'b0;
    logic               rst_ni = 1'b0;
    logic [NumInp-1:0]  inp_valid_i = '0;
    logic [NumInp-1:0]  inp_ready_o;
    logic [NumInp*DW-1:0] inp_data_i = '0;
    logic               oup_valid_o;
    logic               oup_ready_i = 1'b0;
    logic [DW-1:0]      oup_data_o;
    logic [1:0]         oup_idx_o;
    logic               flush_req_i = 1'b0;
    logic               flush_ack_o;
    logic               busy_o;

    logic [2:0]         inp_valid3 = '0;
    logic [2:0]         inp_ready3;
    logic [3*DW-1:0]    inp_data3 = '0;
    logic               oup_valid3;
    logic               oup_ready3 = 1'b0;
    logic [DW-1:0]      oup_data3;
    logic [1:0]         oup_idx3;
    logic               flush_req3 = 1'b0;
    logic               flush_ack3;
    logic               busy3;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_mode;      // 0 run, 1 draining, 2 flushing, 3 acknowledging
    int          m_ptr;
    bit          m_locked;
    int          m_lock_idx;
    int          q_idx[$];
    logic [31:0] q_data[$];
    logic [3:0]  held;
    logic [3:0]  e_ready;
    bit          e_valid, e_req, e_ack, e_busy;
    int          e_grant;

    stream_rr_arb_flush_ctrl #(.NumInp(NumInp), .DataWidth(DW)) u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .inp_valid_i(inp_valid_i), .inp_ready_o(inp_ready_o), .inp_data_i(inp_data_i),
        .oup_valid_o(oup_valid_o), .oup_ready_i(oup_ready_i), .oup_data_o(oup_data_o),
        .oup_idx_o(oup_idx_o), .flush_req_i(flush_req_i), .flush_ack_o(flush_ack_o),
        .busy_o(busy_o)
    );

    stream_rr_arb_flush_ctrl #(.NumInp(3), .DataWidth(DW)) u_dut3 (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .inp_valid_i(inp_valid3), .inp_ready_o(inp_ready3), .inp_data_i(inp_data3),
        .oup_valid_o(oup_valid3), .oup_ready_i(oup_ready3), .oup_data_o(oup_data3),
        .oup_idx_o(oup_idx3), .flush_req_i(flush_req3), .flush_ack_o(flush_ack3),
        .busy_o(busy3)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic model_reset();
        m_mode = 0; m_ptr = 0; m_locked = 0; m_lock_idx = 0;
        q_idx.delete(); q_data.delete(); held = '0;
    endtask

    // Predict combinational outputs for the inputs currently applied.
    task automatic model_eval();
        bit allowed;
        allowed = (m_mode == 0) || (m_mode == 1 && m_locked);
        e_grant = 0;
        e_req   = 0;
        if (m_locked) begin
            e_grant = m_lock_idx;
            e_req   = inp_valid_i[m_lock_idx];
        end else begin
            for (int k = 0; k < NumInp; k++) begin
                if (!e_req && inp_valid_i[(m_ptr + k) % NumInp]) begin
                    e_req   = 1;
                    e_grant = (m_ptr + k) % NumInp;
                end
            end
        end
        e_req   = e_req && allowed;
        e_ready = (e_req && q_idx.size() < 2) ? 4'(1 << e_grant) : 4'b0;
        e_valid = (q_idx.size() > 0) && (m_mode != 2);
        e_ack   = (m_mode == 3);
        e_busy  = (m_mode != 0) || (q_idx.size() > 0);
    endtask

    // Apply the clock edge to the model using the predictions made before it.
    task automatic model_advance();
        bit in_hs, out_hs;
        in_hs  = (e_ready != 0);
        out_hs = e_valid && oup_ready_i;
        if (m_mode == 2) begin
            q_idx.delete(); q_data.delete(); m_ptr = 0;
        end else begin
            if (out_hs) begin
                void'(q_idx.pop_front());
                void'(q_data.pop_front());
            end
            if (in_hs) begin
                q_idx.push_back(e_grant);
                q_data.push_back(inp_data_i[e_grant*DW +: DW]);
                m_ptr = (e_grant + 1) % NumInp;
            end
        end
        if (in_hs) m_locked = 0;
        else if (e_req) begin
            m_locked   = 1;
            m_lock_idx = e_grant;
        end
        held = inp_valid_i & ~e_ready;
        case (m_mode)
            0: if (flush_req_i) m_mode = 1;
            1: if (!m_locked) m_mode = 2;
            2: m_mode = 3;
            default: m_mode = 0;
        endcase
    endtask

    function automatic logic [40:0] obs_vec();
        return {inp_ready_o, oup_valid_o, flush_ack_o, busy_o,
                oup_valid_o ? {oup_idx_o, oup_data_o} : 34'h0};
    endfunction

    function automatic logic [40:0] exp_vec();
        logic [33:0] beat;
        beat = '0;
        if (e_valid) beat = {2'(q_idx[0]), q_data[0]};
        return {e_ready, e_valid, e_ack, e_busy, beat};
    endfunction

    // Requesters with a pending beat keep valid and data stable.
    task automatic applyStimulus(input logic [3:0] vmask, input bit rnd, input bit rdy, input bit flush);
        for (int i = 0; i < NumInp; i++) begin
            if (!held[i]) begin
                inp_valid_i[i] = rnd ? (vmask[i] && ($urandom_range(0, 1) == 1)) : vmask[i];
                inp_data_i[i*DW +: DW] = $urandom();
            end
        end
        oup_ready_i = rdy;
        flush_req_i = flush;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        inp_valid_i = '0; oup_ready_i = 1'b0; flush_req_i = 1'b0;
        inp_valid3 = '0; oup_ready3 = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        inp_valid_i = 4'hF; oup_ready_i = 1'b1; flush_req_i = 1'b1;
        @(posedge clk_i); #3;
        checks += 6;
        if (oup_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b exp 0", oup_valid_o); end
        if (inp_ready_o !== 4'h0) begin errors++; $display("[TB] FAIL reset_ready got %h exp 0", inp_ready_o); end
        if (flush_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_ack got %b exp 0", flush_ack_o); end
        if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b exp 0", busy_o); end
        if (oup_data_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_data got %h exp 0", oup_data_o); end
        if (oup_idx_o !== 2'h0) begin errors++; $display("[TB] FAIL reset_idx got %h exp 0", oup_idx_o); end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int c = 0; c < 7; c++) begin
            applyStimulus(4'hF, 0, 1, 0);
            @(negedge clk_i); model_eval();
            checks += 2;
            if (obs_vec() !== exp_vec()) begin errors++; $display("[TB] FAIL rr_cycle%0d got %h exp %h", c, obs_vec(), exp_vec()); end
            if (inp_ready_o !== 4'(1 << (c % 4))) begin errors++; $display("[TB] FAIL rr_grant%0d got %h exp %h", c, inp_ready_o, 4'(1 << (c % 4))); end
            @(posedge clk_i); model_advance(); #1;
        end
    endtask

    task automatic test_sparse();
        logic [3:0] masks [5];
        logic [3:0] grants [5];
        masks  = '{4'b0010, 4'b1010, 4'b1010, 4'b1010, 4'b1010};
        grants = '{4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0010};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            applyStimulus(masks[c], 0, 1, 0);
            @(negedge clk_i); model_eval();
            checks += 2;
            if (obs_vec() !== exp_vec()) begin errors++; $display("[TB] FAIL sparse_cycle%0d got %h exp %h", c, obs_vec(), exp_vec()); end
            if (inp_ready_o !== grants[c]) begin errors++; $display("[TB] FAIL sparse_grant%0d got %h exp %h", c, inp_ready_o, grants[c]); end
            @(posedge clk_i); model_advance(); #1;
        end
    endtask

    task automatic test_lock();
        do_reset();
        for (int c = 0; c < 9; c++) begin
            applyStimulus((c >= 2 && c <= 4) ? 4'b1110 : 4'hF, 0, c >= 5, 0);
            @(negedge clk_i); model_eval();
            checks++;
            if (obs_vec() !== exp_vec()) begin errors++; $display("[TB] FAIL lock_cycle%0d got %h exp %h", c, obs_vec(), exp_vec()); end
            if (c == 6) begin
                checks++;
                if (inp_ready_o !== 4'b0100) begin errors++; $display("[TB] FAIL lock_resume got %h exp 4", inp_ready_o); end
            end
            @(posedge clk_i); model_advance(); #1;
        end
    endtask

    task automatic test_flush_locked();
        int acks_seen, acks_exp;
        acks_seen = 0; acks_exp = 0;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            applyStimulus(4'hF, 0, c >= 6, c == 3);
            @(negedge clk_i); model_eval();
            acks_seen += int'(flush_ack_o);
            acks_exp  += int'(e_ack);
            checks++;
            if (obs_vec() !== exp_vec()) begin errors++; $display("[TB] FAIL flush_cycle%0d got %h exp %h", c, obs_vec(), exp_vec()); end
            if (c == 8) begin
                checks++;
                if (oup_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid_gate got %b exp 0", oup_valid_o); end
            end
            if (c == 10) begin
                checks++;
                if ({busy_o, inp_ready_o} !== 5'b0_0001) begin errors++; $display("[TB] FAIL flush_after_ack got %b exp 00001", {busy_o, inp_ready_o}); end
            end
            @(posedge clk_i); model_advance(); #1;
        end
        checks++;
        if (acks_seen !== 1 || acks_exp !== 1) begin errors++; $display("[TB] FAIL flush_ack_count got %0d exp 1", acks_seen); end
    endtask

    task automatic test_flush_held();
        int acks_seen, acks_exp;
        acks_seen = 0; acks_exp = 0;
        do_reset();
        for (int c = 0; c < 24; c++) begin
            applyStimulus(4'hF, 1, $urandom_range(0, 1) == 1, 1);
            @(negedge clk_i); model_eval();
            acks_seen += int'(flush_ack_o);
            acks_exp  += int'(e_ack);
            checks++;
            if (obs_vec() !== exp_vec()) begin errors++; $display("[TB] FAIL held_cycle%0d got %h exp %h", c, obs_vec(), exp_vec()); end
            @(posedge clk_i); model_advance(); #1;
        end
        checks++;
        if (acks_seen !== acks_exp) begin errors++; $display("[TB] FAIL held_ack_count got %0d exp %0d", acks_seen, acks_exp); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            applyStimulus(4'hF, 0, 0, 0);
            @(negedge clk_i); model_eval();
            checks++;
            if (obs_vec() !== exp_vec()) begin errors++; $display("[TB] FAIL midrst_fill%0d got %h exp %h", c, obs_vec(), exp_vec()); end
            @(posedge clk_i); model_advance(); #1;
        end
        rst_ni = 1'b0;
        #2;
        checks++;
        if ({oup_valid_o, inp_ready_o, busy_o} !== 6'b0) begin errors++; $display("[TB] FAIL midrst_outputs got %b exp 000000", {oup_valid_o, inp_ready_o, busy_o}); end
        @(posedge clk_i); #1 rst_ni = 1'b1;
        model_reset();
        applyStimulus(4'hF, 0, 1, 0);
        @(negedge clk_i); model_eval();
        checks += 2;
        if (inp_ready_o !== 4'b0001) begin errors++; $display("[TB] FAIL midrst_first_grant got %h exp 1", inp_ready_o); end
        if (obs_vec() !== exp_vec()) begin errors++; $display("[TB] FAIL midrst_model got %h exp %h", obs_vec(), exp_vec()); end
        @(posedge clk_i); model_advance(); #1;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            applyStimulus(4'hF, 1, $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);
            @(negedge clk_i); model_eval();
            checks++;
            if (obs_vec() !== exp_vec()) begin errors++; $display("[TB] FAIL rand_cycle%0d got %h exp %h", c, obs_vec(), exp_vec()); end
            @(posedge clk_i); model_advance(); #1;
        end
    endtask

    task automatic test_wrap_n3();
        do_reset();
        inp_valid3 = 3'b111;
        inp_data3  = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
        oup_ready3 = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk_i);
            checks++;
            if (inp_ready3 !== 3'(1 << (c % 3))) begin errors++; $display("[TB] FAIL wrap_grant%0d got %b exp %b", c, inp_ready3, 3'(1 << (c % 3))); end
            if (c >= 1) begin
                checks++;
                if ({oup_valid3, oup_idx3} !== {1'b1, 2'((c - 1) % 3)}) begin
                    errors++; $display("[TB] FAIL wrap_idx%0d got %b exp %b", c, {oup_valid3, oup_idx3}, {1'b1, 2'((c - 1) % 3)});
                end
            end
            @(posedge clk_i); #1;
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_sparse();
        test_lock();
        test_flush_locked();
        test_flush_held();
        test_reset_midstream();
        test_random();
        test_wrap_n3();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_rr_arb_flush_ctrl.md
Name: stream_rr_arb_flush_ctrl

Overview:
Round-robin arbiter that shares one flushable two-entry spill buffer between NumInp valid/ready requester streams. It tags each granted beat with its source index. A flush FSM sequences an orderly discard of the buffered beats on request from a higher-level controller, for example on an AXI error or abort. It sits in front of the memory-request path of axi_to_mem.

Parameters:
NumInp, 4, number of requester streams (>=2, need not be a power of two)
DataWidth, 32, payload width per requester
IdxWidth, $clog2(NumInp), width of source index (derived; do not override)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
inp_valid_i  in  NumInp  per-requester valid
inp_ready_o  out  NumInp  per-requester ready (one-hot or zero)
inp_data_i  in  NumInp*DataWidth  packed payloads, requester i at [i*DataWidth +: DataWidth]
oup_valid_o  out  1  output valid
oup_ready_i  in  1  output ready
oup_data_o  out  DataWidth  output payload
oup_idx_o  out  IdxWidth  source index of oup_data_o
flush_req_i  in  1  request flush (level or pulse; sampled in IDLE only)
flush_ack_o  out  1  one-cycle pulse, flush complete
busy_o  out  1  high when FSM != IDLE or buffer holds data

Behaviour:
- Reset: rr_q=0, lock_q=0, lock_idx_q=0, state=IDLE, buffer empty. Outputs: oup_valid_o=0, inp_ready_o=0, flush_ack_o=0, busy_o=0, oup_data_o=0, oup_idx_o=0.
- Buffer: two entries holding {idx, data}. Input accepted when buf_in_valid && buf_in_ready. buf_in_ready = not both entries full. Output is the oldest entry. Zero-bubble: one beat per cycle at full throughput.
- Arbitration, when no lock: grant the first i with inp_valid_i[i], searching from rr_q upward and wrapping NumInp-1 -> 0. This is a combinational grant. buf_in_valid = any valid and grant enabled.
- inp_ready_o[g] = buf_in_ready && grant enabled, for the granted g only.
- Lock-in: if buf_in_valid && !buf_in_ready, set lock_q=1 and lock_idx_q=g. While locked, the grant stays fixed at lock_idx_q and is not re-arbitrated. Clear the lock on the handshake.
- Pointer: on each input handshake from index g, rr_q <= (g==NumInp-1) ? 0 : g+1. No update without a handshake.
- FSM states: IDLE, DRAIN_IN, FLUSH, ACK.
- IDLE: normal operation. flush_req_i=1 -> DRAIN_IN.
- DRAIN_IN: no new grants. A locked beat still completes its handshake. When lock_q==0 (including the same-cycle handshake) -> FLUSH. The output side runs normally in this state.
- FLUSH: exactly one cycle. Buffer flush asserted, so both entries are emptied by the next edge. oup_valid_o forced 0, inp_ready_o forced 0. rr_q <= 0. -> ACK.
- ACK: flush_ack_o=1 for one cycle. No grants. -> IDLE.
- flush_req_i outside IDLE is ignored. The requester must re-assert after the ack for a second flush.
- Simultaneous events: a flush request and a handshake in the same IDLE cycle: the handshake completes, then DRAIN_IN. Output handshake in DRAIN_IN proceeds; any beats remaining at FLUSH are discarded.
- AXI stability: once inp_ready_o would be 0 with valid high, grant does not move (lock). oup_valid_o never drops without oup_ready_i, except in FLUSH.
- Reset mid-operation: all state returns to reset values immediately (async); buffered beats are lost.

Decomposition:
- Shared package: state enum (IDLE/DRAIN_IN/FLUSH/ACK, 2-bit), index typedef helper.
- Sub-module: spill_register_flushable, Bypass=0, width IdxWidth+DataWidth, for the buffer.
- Arbiter and FSM stay in this module.

Test Plan:
- NumInp=4, all valid, oup_ready_i=1 constantly -> grants 0,1,2,3,0 on consecutive cycles; oup_idx_o sequence 0,1,2,3 starting 1 cycle after the first grant.
- Valid only on 1 and 3, rr_q=2 -> grant 3 first, then 1; rr_q becomes 0 then 2.
- oup_ready_i=0 for 5 cycles, all valid -> two beats accepted (idx 0,1). Requester 2 then stays granted with inp_ready_o=0 and the grant does not move. Raising inp_valid_i[0] does not steal the grant; after ready returns, idx 2 is next.
- Buffer full with idx 0,1, requester 2 locked, flush_req_i pulse -> req 2 handshakes when space opens, DRAIN_IN->FLUSH. oup_valid_o=0 in FLUSH, flush_ack_o pulse on the following cycle, buffer empty, rr_q=0, busy_o=0 after ack.
- NumInp=3, requester 2 handshakes -> rr_q wraps to 0. flush_req_i held high through ACK -> exactly one flush; a new flush begins only from the IDLE cycle after ack.
- Assert rst_ni=0 mid-stream with buffer full -> oup_valid_o=0, inp_ready_o=0 immediately; after release, first grant goes to index 0.
